// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles every signal of the shared memory port except clk and rst. That
// covers the ifetch requester, the data-memory requester, the downstream
// SDRAM-controller port and the init/busy status lines.
//
// Modports:
//   slave  - the arbiter. It serves both requesters and drives the downstream
//            request together with the completion/status outputs.
//   master - the surrounding system: the pipeline stages and the memory
//            controller.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // Status
  logic              init_done;
  logic              busy;

  // Instruction-fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;

  // Data-memory requester
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [BE_W-1:0]   dm_be;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;

  // Downstream controller port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  init_done,
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  mem_ack, mem_rdata,
    output busy,
    output if_rdata, if_done,
    output dm_rdata, dm_done,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output init_done,
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output mem_ack, mem_rdata,
    input  busy,
    input  if_rdata, if_done,
    input  dm_rdata, dm_done,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares a single SDRAM-controller request port between the instruction-fetch
// stage (if_*) and the data-memory stage (dm_*). Only one access is in flight
// at a time. The granted request is latched into the mem_* registers, and
// mem_req is held until the controller returns a one-cycle mem_ack. The
// returned word is then handed to the winner together with a one-cycle done
// pulse.
//
// Data accesses normally win a collision. A starvation counter tracks how
// many arbitrations ifetch has lost in a row. Once it reaches MAX_WAIT,
// ifetch wins the next collision.
//
// Ports:
//   clk  core clock
//   rst  asynchronous, active-high reset
//   bus  mem_port_arbiter_if.slave, which carries:
//        init_done                   SDRAM init complete (looked at only in INIT)
//        if_req/if_addr              ifetch request, held until if_done
//        if_rdata/if_done            fetched word and completion pulse
//        dm_req/dm_we/dm_addr/dm_wdata/dm_be  data request, held until dm_done
//        dm_rdata/dm_done            read data and completion pulse
//        mem_req/mem_we/mem_addr/mem_wdata/mem_be  downstream request
//        mem_ack/mem_rdata           downstream acknowledge and read data
//        busy                        high in every state except IDLE
//
// Timing: a request seen in IDLE at cycle t raises mem_req at t+1. An ack at
// t+k gives the done pulse at t+k+1 and IDLE at t+k+2.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [3:0]        starve_cnt_r;
  logic [3:0]        starve_cnt_nxt_s;
  logic              grant_s;
  logic              pick_if_s;
  logic              ack_s;
  logic              grant_if_r;

  logic              mem_req_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [BE_W-1:0]   mem_be_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic              if_done_r;
  logic [DATA_W-1:0] dm_rdata_r;
  logic              dm_done_r;
  logic              busy_r;

  // An ack only counts while an access is outstanding. Strays elsewhere are dropped.
  assign ack_s = bus.mem_ack && (state_r == ST_BUSY);

  // Next-state decode and winner selection.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    pick_if_s   = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (bus.init_done) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (bus.if_req && bus.dm_req) begin
          // Collision: data wins unless ifetch has already waited MAX_WAIT times.
          grant_s   = 1'b1;
          pick_if_s = (starve_cnt_r == MAX_WAIT_C);
        end else if (bus.if_req) begin
          grant_s   = 1'b1;
          pick_if_s = 1'b1;
        end else if (bus.dm_req) begin
          grant_s   = 1'b1;
          pick_if_s = 1'b0;
        end else begin
          grant_s   = 1'b0;
          pick_if_s = 1'b0;
        end
        if (grant_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.mem_ack) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_RESP: begin
        // The done pulse goes out in this cycle. Requests are not sampled here.
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  // Starvation counter update. It only moves on a grant.
  always_comb begin
    starve_cnt_nxt_s = starve_cnt_r;
    if (!grant_s) begin
      starve_cnt_nxt_s = starve_cnt_r;
    end else if (pick_if_s) begin
      starve_cnt_nxt_s = 4'd0;
    end else if (bus.if_req && (starve_cnt_r != MAX_WAIT_C)) begin
      starve_cnt_nxt_s = starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_nxt_s = starve_cnt_r;
    end
  end

  // State and starvation counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_INIT;
      starve_cnt_r <= 4'd0;
    end else begin
      state_r      <= state_nxt_s;
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

  // Downstream request: the winner's fields are latched on grant and held
  // until the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_be_r    <= '0;
      grant_if_r  <= 1'b0;
    end else if (grant_s) begin
      mem_req_r  <= 1'b1;
      grant_if_r <= pick_if_s;
      if (pick_if_s) begin
        mem_we_r    <= 1'b0;
        mem_addr_r  <= bus.if_addr;
        mem_wdata_r <= '0;
        mem_be_r    <= '1;
      end else begin
        mem_we_r    <= bus.dm_we;
        mem_addr_r  <= bus.dm_addr;
        mem_wdata_r <= bus.dm_wdata;
        // Byte enables only qualify writes. Reads always fetch the full word.
        if (bus.dm_we) begin
          mem_be_r <= bus.dm_be;
        end else begin
          mem_be_r <= '1;
        end
      end
    end else if (ack_s) begin
      mem_req_r <= 1'b0;
    end else begin
      mem_req_r <= mem_req_r;
    end
  end

  // Completion: route the returned word and a one-cycle done to the winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_r <= '0;
      if_done_r  <= 1'b0;
      dm_rdata_r <= '0;
      dm_done_r  <= 1'b0;
    end else begin
      if_done_r <= ack_s && grant_if_r;
      dm_done_r <= ack_s && !grant_if_r;
      if (ack_s && grant_if_r) begin
        if_rdata_r <= bus.mem_rdata;
      end else begin
        if_rdata_r <= if_rdata_r;
      end
      // A write completion leaves the last read value in place.
      if (ack_s && !grant_if_r && !mem_we_r) begin
        dm_rdata_r <= bus.mem_rdata;
      end else begin
        dm_rdata_r <= dm_rdata_r;
      end
    end
  end

  // busy tracks "state is not IDLE". It is registered from the next state so
  // that it reads 0 while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_be    = mem_be_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.if_done   = if_done_r;
  assign bus.dm_rdata  = dm_rdata_r;
  assign bus.dm_done   = dm_done_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Expected accesses are pushed to a scoreboard queue when the requests are
// driven. They are popped and compared when the DUT issues the downstream
// request and the done pulse comes back.
module tb_mem_port_arbiter;

  localparam int MAXW = 3;
  localparam logic [31:0] IF_A = 32'h0000_0200;
  localparam logic [31:0] DM_A = 32'h3000_0000;

  typedef struct {
    logic        is_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   cnt_m;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_dm_rdata;
  exp_t sb[$];

  // Observations captured by run_access.
  logic        obs_timeout;
  int          obs_t_busy;
  int          obs_t_done;
  int          obs_req_cycles;
  logic        obs_stable;
  logic        obs_early_done;
  logic [31:0] obs_addr;
  logic        obs_we;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_if_done;
  logic        obs_dm_done;
  logic [31:0] obs_if_rdata;
  logic [31:0] obs_dm_rdata;
  logic        obs_req_after;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Waits for mem_req, acks in the ack_after-th BUSY cycle and stops in the done cycle.
  task automatic run_access(input int ack_after, input logic [31:0] rd);
    int n;
    obs_timeout = 1'b0;
    n = 0;
    while (!bus.mem_req && n < 20) begin
      tick();
      n++;
    end
    if (!bus.mem_req) begin
      obs_timeout = 1'b1;
      return;
    end
    obs_t_busy     = cyc;
    obs_addr       = bus.mem_addr;
    obs_we         = bus.mem_we;
    obs_wdata      = bus.mem_wdata;
    obs_be         = bus.mem_be;
    obs_req_cycles = 0;
    obs_stable     = 1'b1;
    obs_early_done = 1'b0;
    for (int i = 1; i <= ack_after; i++) begin
      if (bus.mem_req) obs_req_cycles++;
      if (bus.mem_addr !== obs_addr || bus.mem_we !== obs_we ||
          bus.mem_wdata !== obs_wdata || bus.mem_be !== obs_be) obs_stable = 1'b0;
      if (bus.if_done || bus.dm_done) obs_early_done = 1'b1;
      if (i == ack_after) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
      end
      tick();
    end
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = rd ^ 32'hBAD0_F00D;
    obs_t_done    = cyc;
    obs_if_done   = bus.if_done;
    obs_dm_done   = bus.dm_done;
    obs_if_rdata  = bus.if_rdata;
    obs_dm_rdata  = bus.dm_rdata;
    obs_req_after = bus.mem_req;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.mem_req, bus.busy, bus.if_done, bus.dm_done, bus.mem_we} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=00000", {bus.mem_req, bus.busy, bus.if_done, bus.dm_done, bus.mem_we});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.if_rdata, bus.dm_rdata} !== 132'd0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", {bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.if_rdata, bus.dm_rdata});
    end
  endtask

  task automatic test_init_gating();
    exp_t e;
    int   t0;
    rst = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0040;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.mem_req !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL init_gate cycle %0d got req=%b busy=%b exp req=0 busy=1", i, bus.mem_req, bus.busy);
      end
    end
    e = '{1'b1, 32'h0000_0040, 1'b0, 32'h0, 4'hF, 32'h1111_2222};
    sb.push_back(e);
    bus.init_done = 1'b1;
    t0 = cyc;
    e = sb.pop_front();
    run_access(2, e.rdata);
    checks++;
    if (obs_timeout !== 1'b0 || obs_t_busy !== t0 + 2) begin
      errors++;
      $display("FAIL init_latency got timeout=%b t=%0d exp t=%0d", obs_timeout, obs_t_busy, t0 + 2);
    end
    checks++;
    if (obs_addr !== e.addr || obs_we !== 1'b0 || obs_be !== 4'hF) begin
      errors++;
      $display("FAIL init_fields got addr=%h we=%b be=%h exp addr=%h we=0 be=f", obs_addr, obs_we, obs_be, e.addr);
    end
    exp_if_rdata = e.rdata;
    checks++;
    if (obs_if_done !== 1'b1 || obs_if_rdata !== exp_if_rdata) begin
      errors++;
      $display("FAIL init_done got done=%b rdata=%h exp done=1 rdata=%h", obs_if_done, obs_if_rdata, exp_if_rdata);
    end
    bus.if_req = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    exp_t e;
    e = '{1'b1, 32'h0000_0100, 1'b0, 32'h0, 4'hF, 32'h0000_0013};
    sb.push_back(e);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0100;
    e = sb.pop_front();
    run_access(4, e.rdata);
    checks++;
    if (obs_timeout !== 1'b0 || obs_addr !== e.addr || obs_we !== 1'b0 || obs_be !== 4'hF) begin
      errors++;
      $display("FAIL fetch_fields got to=%b addr=%h we=%b be=%h exp addr=%h we=0 be=f", obs_timeout, obs_addr, obs_we, obs_be, e.addr);
    end
    checks++;
    if (obs_req_cycles !== 4 || obs_req_after !== 1'b0 || obs_stable !== 1'b1 || obs_early_done !== 1'b0) begin
      errors++;
      $display("FAIL fetch_req_len got cycles=%0d after=%b stable=%b early=%b exp 4 0 1 0", obs_req_cycles, obs_req_after, obs_stable, obs_early_done);
    end
    exp_if_rdata = e.rdata;
    checks++;
    if (obs_if_done !== 1'b1 || obs_dm_done !== 1'b0 || obs_if_rdata !== exp_if_rdata) begin
      errors++;
      $display("FAIL fetch_done got if=%b dm=%b rdata=%h exp if=1 dm=0 rdata=%h", obs_if_done, obs_dm_done, obs_if_rdata, exp_if_rdata);
    end
    bus.if_req = 1'b0;
    tick();
    checks++;
    if (bus.if_done !== 1'b0 || bus.busy !== 1'b0 || bus.if_rdata !== exp_if_rdata) begin
      errors++;
      $display("FAIL fetch_after got done=%b busy=%b rdata=%h exp 0 0 %h", bus.if_done, bus.busy, bus.if_rdata, exp_if_rdata);
    end
  endtask

  task automatic test_immediate_ack();
    exp_t e;
    int   t1;
    sb.push_back('{1'b0, 32'h2000_0000, 1'b0, 32'h0, 4'hF, 32'hCAFE_0001});
    sb.push_back('{1'b0, 32'h2000_0000, 1'b0, 32'h0, 4'hF, 32'hCAFE_0002});
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = 32'h2000_0000;
    bus.dm_wdata = 32'h0123_4567;
    bus.dm_be    = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      run_access(1, e.rdata);
      if (k == 0) t1 = obs_t_busy;
      exp_dm_rdata = e.rdata;
      checks++;
      if (obs_timeout !== 1'b0 || obs_t_done !== obs_t_busy + 1 || obs_be !== 4'hF || obs_addr !== e.addr) begin
        errors++;
        $display("FAIL imm_ack_%0d got to=%b lat=%0d be=%h addr=%h exp lat=1 be=f addr=%h", k, obs_timeout, obs_t_done - obs_t_busy, obs_be, obs_addr, e.addr);
      end
      checks++;
      if (obs_dm_done !== 1'b1 || obs_if_done !== 1'b0 || obs_dm_rdata !== exp_dm_rdata) begin
        errors++;
        $display("FAIL imm_done_%0d got dm=%b if=%b rdata=%h exp 1 0 %h", k, obs_dm_done, obs_if_done, obs_dm_rdata, exp_dm_rdata);
      end
    end
    checks++;
    if (obs_t_busy !== t1 + 3) begin
      errors++;
      $display("FAIL turnaround got=%0d exp=3", obs_t_busy - t1);
    end
    bus.dm_req = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.dm_done !== 1'b0) begin
      errors++;
      $display("FAIL imm_idle got busy=%b done=%b exp 0 0", bus.busy, bus.dm_done);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bus.if_done, bus.dm_done, bus.mem_req, bus.busy} !== 4'b0000 || bus.dm_rdata !== exp_dm_rdata) begin
        errors++;
        $display("FAIL stray_ack got flags=%b rdata=%h exp 0000 %h", {bus.if_done, bus.dm_done, bus.mem_req, bus.busy}, bus.dm_rdata, exp_dm_rdata);
      end
      tick();
    end
  endtask

  task automatic test_data_write();
    exp_t e;
    sb.push_back('{1'b0, 32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h5555_AAAA});
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h1000_0004;
    bus.dm_wdata = 32'hDEAD_BEEF;
    bus.dm_be    = 4'b0011;
    e = sb.pop_front();
    run_access(2, e.rdata);
    checks++;
    if (obs_timeout !== 1'b0 || obs_we !== 1'b1 || obs_be !== e.be || obs_wdata !== e.wdata || obs_addr !== e.addr) begin
      errors++;
      $display("FAIL write_fields got to=%b we=%b be=%b wdata=%h addr=%h exp we=1 be=%b wdata=%h addr=%h",
               obs_timeout, obs_we, obs_be, obs_wdata, obs_addr, e.be, e.wdata, e.addr);
    end
    checks++;
    if (obs_dm_done !== 1'b1 || obs_if_done !== 1'b0 || obs_dm_rdata !== exp_dm_rdata || obs_if_rdata !== exp_if_rdata) begin
      errors++;
      $display("FAIL write_done got dm=%b if=%b dm_rdata=%h if_rdata=%h exp 1 0 %h %h", obs_dm_done, obs_if_done, obs_dm_rdata, obs_if_rdata, exp_dm_rdata, exp_if_rdata);
    end
    bus.dm_req = 1'b0;
    bus.dm_we  = 1'b0;
    tick();
    checks++;
    if (bus.dm_done !== 1'b0) begin
      errors++;
      $display("FAIL write_pulse got=%b exp=0", bus.dm_done);
    end
  endtask

  // Pushes n collision grants predicted by the priority/starvation model.
  task automatic push_collisions(input int n, input logic [31:0] seed);
    exp_t e;
    for (int g = 0; g < n; g++) begin
      e.is_if = (cnt_m == MAXW);
      if (e.is_if) cnt_m = 0;
      else if (cnt_m < MAXW) cnt_m++;
      e.addr  = e.is_if ? IF_A : DM_A;
      e.we    = 1'b0;
      e.wdata = 32'h0;
      e.be    = 4'hF;
      e.rdata = seed + 32'(g);
      sb.push_back(e);
    end
  endtask

  task automatic test_priority();
    exp_t e;
    int   g;
    bus.if_addr = IF_A;
    bus.dm_addr = DM_A;
    bus.dm_we   = 1'b0;
    bus.if_req  = 1'b1;
    bus.dm_req  = 1'b1;
    push_collisions(8, 32'hA000_0000);
    g = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      run_access(2, e.rdata);
      if (e.is_if) exp_if_rdata = e.rdata;
      else exp_dm_rdata = e.rdata;
      checks++;
      if (obs_timeout !== 1'b0 || obs_addr !== e.addr) begin
        errors++;
        $display("FAIL prio_grant_%0d got to=%b addr=%h exp addr=%h", g, obs_timeout, obs_addr, e.addr);
      end
      checks++;
      if ({obs_if_done, obs_dm_done} !== {e.is_if, ~e.is_if} || obs_if_rdata !== exp_if_rdata || obs_dm_rdata !== exp_dm_rdata) begin
        errors++;
        $display("FAIL prio_done_%0d got if=%b dm=%b ifr=%h dmr=%h exp if=%b ifr=%h dmr=%h",
                 g, obs_if_done, obs_dm_done, obs_if_rdata, obs_dm_rdata, e.is_if, exp_if_rdata, exp_dm_rdata);
      end
      g++;
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    exp_t e;
    int   n;
    int   r;
    int   g;
    bus.if_req = 1'b1;
    bus.dm_req = 1'b1;
    n = 0;
    while (!bus.mem_req && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== DM_A) begin
      errors++;
      $display("FAIL rst_pre_grant got req=%b addr=%h exp 1 %h", bus.mem_req, bus.mem_addr, DM_A);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got req=%b busy=%b exp 0 0", bus.mem_req, bus.busy);
    end
    bus.if_req  = 1'b0;
    bus.dm_req  = 1'b0;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    checks++;
    if (bus.if_done !== 1'b0 || bus.dm_done !== 1'b0 || bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_no_done got if=%b dm=%b ifr=%h dmr=%h exp 0 0 0 0", bus.if_done, bus.dm_done, bus.if_rdata, bus.dm_rdata);
    end
    exp_if_rdata = 32'h0;
    exp_dm_rdata = 32'h0;
    cnt_m = 0;
    rst = 1'b0;
    r = cyc;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_init_exit got busy=%b req=%b exp 0 0", bus.busy, bus.mem_req);
    end
    bus.if_req = 1'b1;
    bus.dm_req = 1'b1;
    push_collisions(4, 32'hB000_0000);
    g = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      run_access(1, e.rdata);
      if (g == 0) begin
        checks++;
        if (obs_t_busy !== r + 2) begin
          errors++;
          $display("FAIL rst_resume_lat got t=%0d exp t=%0d", obs_t_busy, r + 2);
        end
      end
      checks++;
      if (obs_timeout !== 1'b0 || obs_addr !== e.addr || {obs_if_done, obs_dm_done} !== {e.is_if, ~e.is_if}) begin
        errors++;
        $display("FAIL rst_resume_%0d got to=%b addr=%h if=%b dm=%b exp addr=%h if=%b", g, obs_timeout, obs_addr, obs_if_done, obs_dm_done, e.addr, e.is_if);
      end
      g++;
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    tick();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    cyc           = 0;
    cnt_m         = 0;
    exp_if_rdata  = 32'h0;
    exp_dm_rdata  = 32'h0;
    rst           = 1'b1;
    bus.init_done = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'h0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = 32'h0;
    bus.dm_wdata  = 32'h0;
    bus.dm_be     = 4'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    test_reset();
    test_init_gating();
    test_single_fetch();
    test_immediate_ack();
    test_data_write();
    test_priority();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
